sync_edge_filter: RTL

Per-channel glitch filter and edge/event detector placed directly downstream of the 4-bit two-flop bit synchronizer in the sync_Clk domain. It takes the already-synchronized level bits and accepts a level change only after it has been stable for a programmable number of cycles. For each accepted change it emits single-cycle rise/fall pulses and sets a sticky event flag that software or an FSM clears. It also drives one aggregated interrupt line.

---
 rtl/sync_edge_filter_if.sv | 26 ++
 rtl/sync_edge_filter.sv | 119 +++++++++++
 2 files changed

// File: rtl/sync_edge_filter_if.sv
// sync_edge_filter_if: bundles the level/event signals of sync_edge_filter.
//   master : drives sync_in, rise_en, fall_en, evt_clr; observes the results
//   slave  : the filter; drives filt_out, rise_pulse, fall_pulse, evt_flag, irq
interface sync_edge_filter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sync_in;
  logic             rise_en;
  logic             fall_en;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] evt_flag;
  logic             irq;

  modport master (
    output sync_in, rise_en, fall_en, evt_clr,
    input  filt_out, rise_pulse, fall_pulse, evt_flag, irq
  );

  modport slave (
    input  sync_in, rise_en, fall_en, evt_clr,
    output filt_out, rise_pulse, fall_pulse, evt_flag, irq
  );
endinterface

// File: rtl/sync_edge_filter.sv
// sync_edge_filter: per-channel debounce + edge/event detector for already
// synchronized level bits (sync_Clk domain).
//   sync_Clk, sync_Rstn : clock, asynchronous active-low reset
//   bus (slave)         : sync_in/rise_en/fall_en/evt_clr in;
//                         filt_out/rise_pulse/fall_pulse/evt_flag/irq out
// A level change is accepted after FILT_CYCLES consecutive differing samples.
// Each accepted change produces a one-cycle rise/fall pulse and may set a
// sticky event flag; irq is the OR of all flags.

// One channel: stability counter, filtered level, pulses, sticky flag.
module sync_edge_filter_lane #(
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 2
) (
  input  logic sync_Clk,
  input  logic sync_Rstn,
  input  logic in_lvl,
  input  logic rise_en,
  input  logic fall_en,
  input  logic evt_clr,
  output logic filt,
  output logic rise,
  output logic fall,
  output logic flag
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (in_lvl != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        // Stable long enough: accept. With FILT_CYCLES=1 this is every edge.
        filt_d = in_lvl;
        rise_d = in_lvl;
        fall_d = ~in_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A set outranks a clear on the same edge so no event is dropped.
    if ((rise_d && rise_en) || (fall_d && fall_en)) flag_d = 1'b1;
    else if (evt_clr)                               flag_d = 1'b0;
    else                                            flag_d = flag_q;
  end

  always_ff @(posedge sync_Clk or negedge sync_Rstn) begin
    if (!sync_Rstn) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
    end
  end

  assign filt = filt_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign flag = flag_q;
endmodule

module sync_edge_filter #(
  parameter int WIDTH       = 4,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = (FILT_CYCLES <= 2) ? 1 : $clog2(FILT_CYCLES)
) (
  input  logic              sync_Clk,
  input  logic              sync_Rstn,
  sync_edge_filter_if.slave bus
);
  logic [WIDTH-1:0] sync_in, evt_clr;
  logic [WIDTH-1:0] filt, rise, fall, flag;
  logic             rise_en, fall_en;

  assign sync_in = bus.sync_in;
  assign evt_clr = bus.evt_clr;
  assign rise_en = bus.rise_en;
  assign fall_en = bus.fall_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sync_edge_filter_lane #(
      .FILT_CYCLES (FILT_CYCLES),
      .CNT_W       (CNT_W)
    ) u_lane (
      .sync_Clk  (sync_Clk),
      .sync_Rstn (sync_Rstn),
      .in_lvl    (sync_in[i]),
      .rise_en   (rise_en),
      .fall_en   (fall_en),
      .evt_clr   (evt_clr[i]),
      .filt      (filt[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .flag      (flag[i])
    );
  end

  assign bus.filt_out   = filt;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.evt_flag   = flag;
  // Registers only: no input reaches irq combinationally.
  assign bus.irq        = |flag;
endmodule
